// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register with stall and redirect.
// Optional macro FETCH_MISALIGN_CHK_EN enables the sticky misaligned-redirect flag.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc,
   input  logic [31:0] instruction,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        misalign_err
);

   logic stall;
   assign stall = if_valid && !id_ready;

   // Low PC bits are forced to zero on every load path so pc stays word aligned.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= {RESET_PC[31:2], 2'b00};
         if_valid <= 1'b0;
         if_pc    <= 32'h0;
         if_instr <= NOP_INSTR;
      end else if (redirect_valid) begin
         pc       <= {redirect_target[31:2], 2'b00};
         if_valid <= 1'b0;
         if_pc    <= 32'h0;
         if_instr <= NOP_INSTR;
      end else if (!stall) begin
         pc       <= pc + 32'd4;
         if_valid <= 1'b1;
         if_pc    <= pc;
         if_instr <= instruction;
      end
   end

`ifdef FETCH_MISALIGN_CHK_EN
   always_ff @(posedge clk) begin
      if (reset)
         misalign_err <= 1'b0;
      else if (redirect_valid && (redirect_target[1:0] != 2'b00))
         misalign_err <= 1'b1;
   end
`else
   logic unused_target_lsbs;
   assign unused_target_lsbs = ^redirect_target[1:0];
   assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, sequential fetch, stall, redirect,
// misalign flag, reset-over-redirect and PC wrap (second instance with RESET_PC near the top).
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset, redirect_valid, id_ready;
   logic [31:0] redirect_target, pc, instruction, if_pc, if_instr;
   logic        if_valid, misalign_err;

   logic        reset_w;
   logic [31:0] pc_w, instruction_w, if_pc_w, if_instr_w;
   logic        if_valid_w, misalign_err_w;

   logic [31:0] mem [0:63];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign instruction   = mem[pc[7:2]];
   assign instruction_w = ~pc_w;

   fetch_unit dut (
      .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .id_ready(id_ready), .if_valid(if_valid), .if_pc(if_pc),
      .if_instr(if_instr), .misalign_err(misalign_err)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk(clk), .reset(reset_w), .pc(pc_w), .instruction(instruction_w),
      .redirect_valid(1'b0), .redirect_target(32'h0),
      .id_ready(1'b1), .if_valid(if_valid_w), .if_pc(if_pc_w),
      .if_instr(if_instr_w), .misalign_err(misalign_err_w)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
      step(); step();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_valid); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc got %h want 0", if_pc); end
      checks++; if (if_instr !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", if_instr, NOP); end
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign_err); end
   endtask

   task automatic test_sequential();
      reset = 1'b0;
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0050_0093)
         begin errors++; $display("FAIL seq_edge1 got v=%b pc=%h ins=%h want v=1 pc=0 ins=00500093", if_valid, if_pc, if_instr); end
      checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc1 got %h want 4", pc); end
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h0030_0113)
         begin errors++; $display("FAIL seq_edge2 got v=%b pc=%h ins=%h want v=1 pc=4 ins=00300113", if_valid, if_pc, if_instr); end
      step();
      checks++; if (if_pc !== 32'h8 || pc !== 32'hC || if_instr !== 32'h0100_0002)
         begin errors++; $display("FAIL seq_edge3 got if_pc=%h pc=%h ins=%h want 8 c 01000002", if_pc, pc, if_instr); end
   endtask

   task automatic test_stall();
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (pc !== 32'hC || if_pc !== 32'h8 || if_instr !== 32'h0100_0002 || if_valid !== 1'b1)
            begin errors++; $display("FAIL stall_hold%0d got pc=%h if_pc=%h ins=%h v=%b want c 8 01000002 1", i, pc, if_pc, if_instr, if_valid); end
      end
      id_ready = 1'b1;
      step();
      checks++; if (if_pc !== 32'hC || pc !== 32'h10 || if_instr !== 32'h0100_0003)
         begin errors++; $display("FAIL stall_release got if_pc=%h pc=%h ins=%h want c 10 01000003", if_pc, pc, if_instr); end
   endtask

   task automatic test_redirect();
      id_ready = 1'b0;
      redirect_valid = 1'b1; redirect_target = 32'h0000_0040;
      step();
      checks++; if (if_valid !== 1'b0 || if_instr !== NOP || pc !== 32'h40 || if_pc !== 32'h0)
         begin errors++; $display("FAIL redir_edge1 got v=%b ins=%h pc=%h if_pc=%h want 0 13 40 0", if_valid, if_instr, pc, if_pc); end
      redirect_valid = 1'b0; redirect_target = 32'hDEAD_BEEF; id_ready = 1'b1;
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h0100_0010)
         begin errors++; $display("FAIL redir_edge2 got v=%b if_pc=%h ins=%h want 1 40 01000010", if_valid, if_pc, if_instr); end
      step();
      checks++; if (pc !== 32'h48 || if_pc !== 32'h44)
         begin errors++; $display("FAIL redir_ignore got pc=%h if_pc=%h want 48 44", pc, if_pc); end
   endtask

   task automatic test_misalign();
      logic exp_err;
`ifdef FETCH_MISALIGN_CHK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      redirect_valid = 1'b1; redirect_target = 32'h0000_0022;
      step();
      checks++; if (pc !== 32'h20 || misalign_err !== exp_err)
         begin errors++; $display("FAIL misalign_edge got pc=%h err=%b want 20 %b", pc, misalign_err, exp_err); end
      redirect_valid = 1'b0;
      step(); step();
      checks++; if (misalign_err !== exp_err || if_pc !== 32'h24 || pc[1:0] !== 2'b00)
         begin errors++; $display("FAIL misalign_sticky got err=%b if_pc=%h pc=%h want %b 24 aligned", misalign_err, if_pc, pc, exp_err); end
   endtask

   task automatic test_reset_redirect();
      id_ready = 1'b0;
      reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
      step();
      checks++; if (pc !== 32'h0 || if_valid !== 1'b0 || if_instr !== NOP || misalign_err !== 1'b0)
         begin errors++; $display("FAIL rst_redir got pc=%h v=%b ins=%h err=%b want 0 0 13 0", pc, if_valid, if_instr, misalign_err); end
      reset = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0050_0093 || pc !== 32'h4)
         begin errors++; $display("FAIL rst_release got v=%b if_pc=%h ins=%h pc=%h want 1 0 00500093 4", if_valid, if_pc, if_instr, pc); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_seq [4];
      exp_seq[0] = 32'hFFFF_FFF8; exp_seq[1] = 32'hFFFF_FFFC;
      exp_seq[2] = 32'h0000_0000; exp_seq[3] = 32'h0000_0004;
      reset_w = 1'b1;
      step();
      checks++; if (pc_w !== 32'hFFFF_FFF8 || if_valid_w !== 1'b0)
         begin errors++; $display("FAIL wrap_reset got pc=%h v=%b want fffffff8 0", pc_w, if_valid_w); end
      reset_w = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (if_valid_w !== 1'b1 || if_pc_w !== exp_seq[i] || if_instr_w !== ~exp_seq[i] || pc_w !== exp_seq[i] + 32'd4)
            begin errors++; $display("FAIL wrap_seq%0d got if_pc=%h ins=%h pc=%h want if_pc=%h", i, if_pc_w, if_instr_w, pc_w, exp_seq[i]); end
      end
      checks++; if (misalign_err_w !== 1'b0)
         begin errors++; $display("FAIL wrap_misalign got %b want 0", misalign_err_w); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0100_0000 + i;
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h0030_0113;
      reset_w = 1'b1;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_misalign();
      test_reset_redirect();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
